// File: rtl/ox_credit_init_gen.sv
// OmniXtend credit-initialisation packet generator.
// Walks enabled TileLink channels and emits one credit packet per channel over OX2M.
module ox_credit_init_gen #(
    parameter logic [47:0] SRC_MAC      = 48'h001232_FFFFF0,
    parameter logic [47:0] DST_MAC      = 48'h000000_000000,
    parameter logic [4:0]  CH_MASK      = 5'b01010,
    parameter int unsigned QQWD_PER_PKT = 3,
    parameter logic [7:0]  CREDIT_EXP   = 8'd12
) (
    input  logic         clk,
    input  logic         rst_,
    input  logic         pwr2cig_start,
    input  logic         cig_reinit,
    input  logic         ox2cig_grant,
    input  logic         ox2cig_ready,
    output logic         cig2ox_req,
    output logic [255:0] cig2ox_data,
    output logic         cig2ox_valid,
    output logic         cig2ox_last,
    output logic [2:0]   cig2ox_qqwd_cnt,
    output logic         cig2ox_pkt_done,
    output logic [2:0]   cig_ch_id,
    output logic         cig_init_done,
    output logic         cig_busy
);

    typedef enum logic [5:0] {
        S_PWR_ON = 6'b000001,
        S_IDLE   = 6'b000010,
        S_SCAN   = 6'b000100,
        S_REQ    = 6'b001000,
        S_SEND   = 6'b010000,
        S_DONE   = 6'b100000
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(QQWD_PER_PKT - 1);

    function automatic logic [47:0] swap6(input logic [47:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24], v[39:32], v[47:40]};
    endfunction

    localparam logic [47:0] SRC_SW = swap6(SRC_MAC);
    localparam logic [47:0] DST_SW = swap6(DST_MAC);

    function automatic logic [255:0] qqwd(input logic [2:0] idx, input logic [2:0] ch);
        logic [2:0] code;
        code = ch + 3'd1;
        if (idx == 3'd0)
            return {15'h0, code, 14'h0900, 24'h0, CREDIT_EXP, 32'h0000_AAAA,
                    SRC_SW, DST_SW, 64'h0046};
        else if (idx == LAST_IDX)
            return 256'h1 << 104;
        else
            return 256'h0;
    endfunction

    state_t       r_state;
    logic [2:0]   r_ptr;
    logic         r_pend;
    logic         r_req;
    logic [255:0] r_data;
    logic         r_valid;
    logic         r_last;
    logic [2:0]   r_cnt;
    logic         r_pkt_done;
    logic [2:0]   r_ch_id;
    logic         r_init_done;

    logic         w_found;
    logic [2:0]   w_next;

    // Lowest enabled channel at or above the pointer.
    always_comb begin
        w_found = 1'b0;
        w_next  = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (CH_MASK[i] && (3'(i) >= r_ptr)) begin
                w_found = 1'b1;
                w_next  = 3'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            r_state     <= S_PWR_ON;
            r_ptr       <= 3'd0;
            r_pend      <= 1'b0;
            r_req       <= 1'b0;
            r_data      <= 256'h0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_cnt       <= 3'd0;
            r_pkt_done  <= 1'b0;
            r_ch_id     <= 3'd0;
            r_init_done <= 1'b0;
        end else begin
            r_pkt_done <= 1'b0;
            if (cig_reinit && (r_state != S_PWR_ON) &&
                !((r_state == S_IDLE) && r_init_done))
                r_pend <= 1'b1;
            unique case (r_state)
                S_PWR_ON: begin
                    if (pwr2cig_start)
                        r_state <= S_SCAN;
                end
                S_IDLE: begin
                    if (r_pend) begin
                        r_pend  <= 1'b0;
                        r_ptr   <= 3'd0;
                        r_state <= S_SCAN;
                    end else if (cig_reinit && r_init_done) begin
                        r_init_done <= 1'b0;
                        r_ptr       <= 3'd0;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (w_found) begin
                        r_ptr   <= w_next;
                        r_ch_id <= w_next;
                        r_state <= S_REQ;
                    end else begin
                        // A pending restart suppresses the done level.
                        r_ptr       <= 3'd0;
                        r_init_done <= !(r_pend || cig_reinit);
                        r_state     <= S_IDLE;
                    end
                end
                S_REQ: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (ox2cig_grant) begin
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_data  <= qqwd(3'd0, r_ch_id);
                        r_cnt   <= 3'd0;
                        r_last  <= 1'b0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (r_valid && ox2cig_ready) begin
                        if (r_cnt == LAST_IDX) begin
                            r_valid    <= 1'b0;
                            r_last     <= 1'b0;
                            r_cnt      <= 3'd0;
                            r_data     <= 256'h0;
                            r_pkt_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_cnt  <= r_cnt + 3'd1;
                            r_data <= qqwd(r_cnt + 3'd1, r_ch_id);
                            r_last <= ((r_cnt + 3'd1) == LAST_IDX);
                        end
                    end
                end
                S_DONE: begin
                    r_ptr   <= r_ptr + 3'd1;
                    r_state <= S_SCAN;
                end
                default: r_state <= S_PWR_ON;
            endcase
        end
    end

    assign cig2ox_req      = r_req;
    assign cig2ox_data     = r_data;
    assign cig2ox_valid    = r_valid;
    assign cig2ox_last     = r_last;
    assign cig2ox_qqwd_cnt = r_cnt;
    assign cig2ox_pkt_done = r_pkt_done;
    assign cig_ch_id       = r_ch_id;
    assign cig_init_done   = r_init_done;
    assign cig_busy        = !((r_state == S_PWR_ON) || (r_state == S_IDLE));

endmodule

// File: tb/tb_ox_credit_init_gen.sv
// Bench for ox_credit_init_gen: three parameterisations, scoreboard of expected beats.
module tb_ox_credit_init_gen;

    localparam logic [47:0] SRC = 48'h001232_FFFFF0;
    localparam logic [47:0] DST = 48'h000000_000000;
    localparam int         NQ  [3] = '{3, 5, 2};
    localparam logic [4:0] MSK [3] = '{5'b01010, 5'b10001, 5'b00000};

    typedef struct packed {
        logic [255:0] d;
        logic [2:0]   cnt;
        logic         last;
        logic [2:0]   ch;
    } beat_t;

    typedef struct {
        int          inst;
        int          npkt;
        logic [2:0]  ch_a;
        logic [2:0]  ch_b;
        logic [31:0] w0_a;
        logic [31:0] w0_b;
        int          cyc;
    } vec_t;

    logic         clk;
    logic         rst    [3];
    logic         start  [3];
    logic         reinit [3];
    logic         grant  [3];
    logic         ready  [3];
    logic         req    [3];
    logic [255:0] data   [3];
    logic         valid  [3];
    logic         last   [3];
    logic [2:0]   cnt    [3];
    logic         done   [3];
    logic [2:0]   ch     [3];
    logic         idone  [3];
    logic         busy   [3];

    int checks, failures;
    int cyc, pkt_cnt, hs, reqcyc, vwr;
    int rc [3];
    int gdly [3];
    logic lgrant [3];
    beat_t sbq [$];
    logic [31:0] h_w0 [$];
    logic [31:0] h_w1 [$];
    logic [2:0]  h_ch [$];
    vec_t vt [3];

    ox_credit_init_gen u_def (
        .clk(clk), .rst_(rst[0]), .pwr2cig_start(start[0]), .cig_reinit(reinit[0]),
        .ox2cig_grant(grant[0]), .ox2cig_ready(ready[0]), .cig2ox_req(req[0]),
        .cig2ox_data(data[0]), .cig2ox_valid(valid[0]), .cig2ox_last(last[0]),
        .cig2ox_qqwd_cnt(cnt[0]), .cig2ox_pkt_done(done[0]), .cig_ch_id(ch[0]),
        .cig_init_done(idone[0]), .cig_busy(busy[0])
    );

    ox_credit_init_gen #(.CH_MASK(5'b10001), .QQWD_PER_PKT(5)) u_q5 (
        .clk(clk), .rst_(rst[1]), .pwr2cig_start(start[1]), .cig_reinit(reinit[1]),
        .ox2cig_grant(grant[1]), .ox2cig_ready(ready[1]), .cig2ox_req(req[1]),
        .cig2ox_data(data[1]), .cig2ox_valid(valid[1]), .cig2ox_last(last[1]),
        .cig2ox_qqwd_cnt(cnt[1]), .cig2ox_pkt_done(done[1]), .cig_ch_id(ch[1]),
        .cig_init_done(idone[1]), .cig_busy(busy[1])
    );

    ox_credit_init_gen #(.CH_MASK(5'b00000), .QQWD_PER_PKT(2)) u_z (
        .clk(clk), .rst_(rst[2]), .pwr2cig_start(start[2]), .cig_reinit(reinit[2]),
        .ox2cig_grant(grant[2]), .ox2cig_ready(ready[2]), .cig2ox_req(req[2]),
        .cig2ox_data(data[2]), .cig2ox_valid(valid[2]), .cig2ox_last(last[2]),
        .cig2ox_qqwd_cnt(cnt[2]), .cig2ox_pkt_done(done[2]), .cig_ch_id(ch[2]),
        .cig_init_done(idone[2]), .cig_busy(busy[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chkw(input string nm, input logic [271:0] act, input logic [271:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] mk(input int c, input int k, input int n);
        logic [47:0] s, d;
        logic [31:0] w0;
        for (int b = 0; b < 6; b++) begin
            s[8*b +: 8] = SRC[8*(5-b) +: 8];
            d[8*b +: 8] = DST[8*(5-b) +: 8];
        end
        w0 = 32'h0000_0900 + 32'(c + 1) * 32'h4000;
        if (k == 0)
            return {w0, 32'h0000_000C, 32'h0000_AAAA, s, d, 64'h46};
        else if (k == n - 1)
            return 256'h1 << 104;
        return 256'h0;
    endfunction

    task automatic push_seq(input int i);
        beat_t b;
        for (int c = 0; c < 5; c++) begin
            if (MSK[i][c]) begin
                for (int k = 0; k < NQ[i]; k++) begin
                    b.d    = mk(c, k, NQ[i]);
                    b.cnt  = 3'(k);
                    b.last = (k == NQ[i] - 1);
                    b.ch   = 3'(c);
                    sbq.push_back(b);
                end
            end
        end
    endtask

    task automatic accept(input int i);
        beat_t got, exp;
        got = {data[i], cnt[i], last[i], ch[i]};
        hs++;
        if (cnt[i] == 3'd0) begin
            h_w0.push_back(data[i][255:224]);
            h_w1.push_back(data[i][223:192]);
            h_ch.push_back(ch[i]);
        end
        if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL beat_unexpected: got %h want none", got);
        end else begin
            exp = sbq.pop_front();
            chkw("beat", 272'(got), 272'(exp));
        end
    endtask

    // Inputs are settled here, one time unit after the previous edge.
    task automatic step();
        for (int i = 0; i < 3; i++) begin
            if (req[i] === 1'b1) rc[i]++;
            else rc[i] = 0;
            grant[i]  = (req[i] === 1'b1) && (rc[i] > gdly[i]);
            lgrant[i] = grant[i];
            if (req[i] === 1'b1) reqcyc++;
            if (valid[i] === 1'b1 && req[i] === 1'b1) vwr++;
            if (done[i] === 1'b1) pkt_cnt++;
            if (valid[i] === 1'b1 && ready[i] === 1'b1) accept(i);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr();
        cyc = 0; pkt_cnt = 0; hs = 0; reqcyc = 0; vwr = 0;
        sbq.delete(); h_w0.delete(); h_w1.delete(); h_ch.delete();
    endtask

    task automatic reset_inst(input int i);
        rst[i] = 1'b1;
        step();
        rst[i] = 1'b0;
    endtask

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        step();
        start[i] = 1'b0;
    endtask

    task automatic run_done(input int i, input int budget, input string nm);
        int n;
        n = 0;
        while (idone[i] !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        if (idone[i] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: init_done=%b want 1", nm, idone[i]);
        end
    endtask

    task automatic wait_beat(input int i, input logic [2:0] c, input string nm);
        int n;
        n = 0;
        while (!(valid[i] === 1'b1 && cnt[i] === c) && n < 200) begin
            step();
            n++;
        end
        if (!(valid[i] === 1'b1 && cnt[i] === c)) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: valid=%b cnt=%0d want beat %0d", nm, valid[i], cnt[i], c);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1; start[i] = 1'b0; reinit[i] = 1'b0;
            grant[i] = 1'b0; ready[i] = 1'b1; gdly[i] = 1; rc[i] = 0;
        end
        clr();
        step();
        step();
        for (int i = 0; i < 3; i++) begin
            chkw("reset_outs", 272'({req[i], data[i], valid[i], last[i], cnt[i],
                 done[i], ch[i], idone[i], busy[i]}), 272'(0));
            rst[i] = 1'b0;
        end

        vt[0] = '{0, 2, 3'd1, 3'd3, 32'h0000_8900, 32'h0001_0900, 18};
        vt[1] = '{1, 2, 3'd0, 3'd4, 32'h0000_4900, 32'h0001_4900, 22};
        vt[2] = '{2, 0, 3'd0, 3'd0, 32'h0, 32'h0, 2};

        for (int v = 0; v < 3; v++) begin
            int i;
            i = vt[v].inst;
            reset_inst(i);
            clr();
            push_seq(i);
            pulse_start(i);
            run_done(i, 300, "seq");
            chk("seq_cycles", cyc, vt[v].cyc);
            chk("seq_pkts", pkt_cnt, vt[v].npkt);
            chk("seq_beats", hs, vt[v].npkt * NQ[i]);
            chk("seq_sb_empty", sbq.size(), 0);
            chk("seq_req_cycles", reqcyc, 2 * vt[v].npkt);
            chk("seq_hdrs", h_ch.size(), vt[v].npkt);
            if (vt[v].npkt >= 2 && h_ch.size() >= 2) begin
                chk("hdr_ch_first", int'(h_ch[0]), int'(vt[v].ch_a));
                chk("hdr_w0_first", int'(h_w0[0]), int'(vt[v].w0_a));
                chk("hdr_ch_last", int'(h_ch[h_ch.size()-1]), int'(vt[v].ch_b));
                chk("hdr_w0_last", int'(h_w0[h_w0.size()-1]), int'(vt[v].w0_b));
                foreach (h_w1[k]) chk("hdr_credit", int'(h_w1[k]), 32'h0000_000C);
            end
        end

        // Grant held off for 20 req cycles.
        reset_inst(0);
        clr();
        gdly[0] = 20;
        push_seq(0);
        pulse_start(0);
        wait_beat(0, 3'd0, "gw");
        chk("gw_req_cycles", reqcyc, 21);
        chk("gw_valid_during_req", vwr, 0);
        chk("gw_send_after_grant", int'(lgrant[0]), 1);
        run_done(0, 300, "gw");
        chk("gw_pkts", pkt_cnt, 2);
        chk("gw_sb_empty", sbq.size(), 0);
        gdly[0] = 1;

        // Ready stall on beat 2 of a five-beat packet.
        reset_inst(1);
        clr();
        push_seq(1);
        pulse_start(1);
        wait_beat(1, 3'd2, "stall");
        ready[1] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chkw("stall_hold", 272'({valid[1], cnt[1], last[1], data[1]}),
                 272'({1'b1, 3'd2, 1'b0, 256'h0}));
        end
        ready[1] = 1'b1;
        run_done(1, 300, "stall");
        chk("stall_beats", hs, 10);
        chk("stall_pkts", pkt_cnt, 2);
        chk("stall_cycles", cyc, 26);
        chk("stall_sb_empty", sbq.size(), 0);

        // Two reinit pulses mid-packet collapse into one extra sequence.
        reset_inst(0);
        clr();
        push_seq(0);
        pulse_start(0);
        wait_beat(0, 3'd0, "ri");
        reinit[0] = 1'b1; step(); reinit[0] = 1'b0;
        step();
        reinit[0] = 1'b1; step(); reinit[0] = 1'b0;
        push_seq(0);
        run_done(0, 400, "ri");
        chk("ri_cycles", cyc, 36);
        chk("ri_pkts", pkt_cnt, 4);
        chk("ri_beats", hs, 12);
        chk("ri_sb_empty", sbq.size(), 0);

        // Reinit while idle and done.
        clr();
        push_seq(0);
        reinit[0] = 1'b1; step(); reinit[0] = 1'b0;
        chk("ri_idle_clears_done", int'(idone[0]), 0);
        chk("ri_idle_busy", int'(busy[0]), 1);
        run_done(0, 300, "ri_idle");
        chk("ri_idle_cycles", cyc, 18);
        chk("ri_idle_pkts", pkt_cnt, 2);
        chk("ri_idle_sb_empty", sbq.size(), 0);

        // Reset in the middle of beat 1, then replay.
        reset_inst(0);
        clr();
        push_seq(0);
        pulse_start(0);
        wait_beat(0, 3'd1, "rst");
        ready[0] = 1'b0;
        rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        ready[0] = 1'b1;
        chkw("rst_mid_outs", 272'({req[0], data[0], valid[0], last[0], cnt[0],
             done[0], ch[0], idone[0], busy[0]}), 272'(0));
        step(); step(); step();
        chk("rst_stays_pwr_on", int'({busy[0], req[0], valid[0], idone[0]}), 0);
        clr();
        push_seq(0);
        pulse_start(0);
        run_done(0, 300, "rst_replay");
        chk("rst_replay_cycles", cyc, 18);
        chk("rst_replay_pkts", pkt_cnt, 2);
        chk("rst_replay_sb_empty", sbq.size(), 0);
        if (h_ch.size() > 0) chk("rst_replay_first_ch", int'(h_ch[0]), 1);

        // A second start after init is ignored.
        pulse_start(0);
        step(); step();
        chk("late_start_ignored", int'({busy[0], idone[0]}), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
